// File: rtl/regfile_2r1w.sv
// regfile_2r1w: 2**AWIDTH x DWIDTH register file, two registered read ports,
// one byte-enabled write port with write-first bypass, and a bulk-clear FSM.
// Optional feature: define REGFILE_PARITY_EN for a stored even-parity bit per
// entry, checked on every read return (par_err); otherwise par_err is tied 0.
module regfile_2r1w #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wren,
  input  logic [AWIDTH-1:0]    waddr,
  input  logic [DWIDTH-1:0]    wdata,
  input  logic [DWIDTH/8-1:0]  wbe,
  input  logic                 rden_a,
  input  logic [AWIDTH-1:0]    raddr_a,
  output logic [DWIDTH-1:0]    rdata_a,
  output logic                 rvalid_a,
  input  logic                 rden_b,
  input  logic [AWIDTH-1:0]    raddr_b,
  output logic [DWIDTH-1:0]    rdata_b,
  output logic                 rvalid_b,
  input  logic                 clr_req,
  output logic                 busy,
  output logic                 par_err
);

  localparam int BEW   = DWIDTH / 8;
  localparam int DEPTH = 1 << AWIDTH;
`ifdef REGFILE_PARITY_EN
  localparam int SW = DWIDTH + 1;
`else
  localparam int SW = DWIDTH;
`endif

  typedef enum logic {IDLE, CLEAR} state_e;

  state_e            state_q;
  logic [AWIDTH-1:0] cnt_q;
  logic              busy_q;
  logic [SW-1:0]     mem_q [DEPTH];

  logic [DWIDTH-1:0] rdata_a_q, rdata_b_q;
  logic              rvalid_a_q, rvalid_b_q, par_err_q;

  logic              wr_acc, rd_a_acc, rd_b_acc;
  logic [DWIDTH-1:0] merged_d;
  logic [SW-1:0]     wword_d, rword_a_d, rword_b_d;
  logic              par_err_d;

  assign wr_acc   = wren   && !busy_q;
  assign rd_a_acc = rden_a && !busy_q;
  assign rd_b_acc = rden_b && !busy_q;

  // Byte-merge the incoming write into the currently stored word
  always_comb begin
    merged_d = mem_q[waddr][DWIDTH-1:0];
    for (int unsigned i = 0; i < BEW; i++) begin
      if (wbe[i]) merged_d[8*i +: 8] = wdata[8*i +: 8];
    end
  end

`ifdef REGFILE_PARITY_EN
  assign wword_d = {^merged_d, merged_d};
`else
  assign wword_d = merged_d;
`endif

  // Write-first bypass: a read of the address being written sees the merged word
  always_comb begin
    rword_a_d = (wr_acc && (raddr_a == waddr)) ? wword_d : mem_q[raddr_a];
    rword_b_d = (wr_acc && (raddr_b == waddr)) ? wword_d : mem_q[raddr_b];
  end

`ifdef REGFILE_PARITY_EN
  assign par_err_d = (rd_a_acc && (^rword_a_d)) || (rd_b_acc && (^rword_b_d));
`else
  assign par_err_d = 1'b0;
`endif

  // Storage array: clear sweep has priority; writes are blocked while busy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (state_q == CLEAR) begin
      mem_q[cnt_q] <= '0;
    end else if (wr_acc) begin
      mem_q[waddr] <= wword_d;
    end
  end

  // Bulk-clear FSM with registered busy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else if (state_q == IDLE) begin
      if (clr_req) begin
        state_q <= CLEAR;
        cnt_q   <= '0;
        busy_q  <= 1'b1;
      end
    end else begin
      if (cnt_q == '1) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        busy_q  <= 1'b0;
      end else begin
        cnt_q <= cnt_q + AWIDTH'(1);
      end
    end
  end

  // Registered read returns; rdata holds when no read is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_a_q  <= '0;
      rdata_b_q  <= '0;
      rvalid_a_q <= 1'b0;
      rvalid_b_q <= 1'b0;
      par_err_q  <= 1'b0;
    end else begin
      rvalid_a_q <= rd_a_acc;
      rvalid_b_q <= rd_b_acc;
      par_err_q  <= par_err_d;
      if (rd_a_acc) rdata_a_q <= rword_a_d[DWIDTH-1:0];
      if (rd_b_acc) rdata_b_q <= rword_b_d[DWIDTH-1:0];
    end
  end

  assign rdata_a  = rdata_a_q;
  assign rdata_b  = rdata_b_q;
  assign rvalid_a = rvalid_a_q;
  assign rvalid_b = rvalid_b_q;
  assign busy     = busy_q;
  assign par_err  = par_err_q;

endmodule

// File: tb/tb_regfile_2r1w.sv
// Scoreboard bench for regfile_2r1w (DWIDTH=16, AWIDTH=2): the driver updates
// an array model and queues expected returns; a monitor pops and compares.
module tb_regfile_2r1w;

  localparam int DW    = 16;
  localparam int AW    = 2;
  localparam int BEW   = DW / 8;
  localparam int DEPTH = 1 << AW;

  logic           clk, rst_n;
  logic           wren, rden_a, rden_b, clr_req;
  logic [AW-1:0]  waddr, raddr_a, raddr_b;
  logic [DW-1:0]  wdata, rdata_a, rdata_b;
  logic [BEW-1:0] wbe;
  logic           rvalid_a, rvalid_b, busy, par_err;

  regfile_2r1w #(.DWIDTH(DW), .AWIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .wren(wren), .waddr(waddr), .wdata(wdata), .wbe(wbe),
    .rden_a(rden_a), .raddr_a(raddr_a), .rdata_a(rdata_a), .rvalid_a(rvalid_a),
    .rden_b(rden_b), .raddr_b(raddr_b), .rdata_b(rdata_b), .rvalid_b(rvalid_b),
    .clr_req(clr_req), .busy(busy), .par_err(par_err)
  );

  typedef struct {int cyc; logic [DW-1:0] d; logic pe;} exp_t;
  typedef struct {int cyc; logic b;} bexp_t;

  exp_t  qa[$], qb[$];
  bexp_t qbusy[$];

  logic [DW-1:0] mm  [DEPTH];
  logic          bad [DEPTH];
  int            clear_left;
  int            cyc;
  int            errors, checks;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      mm[i]  = '0;
      bad[i] = 1'b0;
    end
    clear_left = 0;
  endtask

  // Apply one cycle of stimulus at the negedge and record what the next edge must produce
  task automatic step(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input logic [BEW-1:0] be, input logic ea, input logic [AW-1:0] a,
                      input logic eb, input logic [AW-1:0] b, input logic clr);
    int nc;
    @(negedge clk);
    wren = we; waddr = wa; wdata = wd; wbe = be;
    rden_a = ea; raddr_a = a; rden_b = eb; raddr_b = b; clr_req = clr;
    nc = cyc + 1;
    if (clear_left == 0) begin
      if (we) begin
        for (int i = 0; i < BEW; i++)
          if (be[i]) mm[wa][8*i +: 8] = wd[8*i +: 8];
        bad[wa] = 1'b0;
      end
      if (ea) qa.push_back('{nc, mm[a], bad[a]});
      if (eb) qb.push_back('{nc, mm[b], bad[b]});
      if (clr) clear_left = DEPTH;
    end else begin
      mm[DEPTH - clear_left]  = '0;
      bad[DEPTH - clear_left] = 1'b0;
      clear_left--;
    end
    qbusy.push_back('{nc, clear_left > 0});
  endtask

  task automatic idle();
    step(1'b0, '0, '0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic rd2(input logic [AW-1:0] a, input logic [AW-1:0] b);
    step(1'b0, '0, '0, '0, 1'b1, a, 1'b1, b, 1'b0);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_rdata_a"}, rdata_a, '0);
    chk({tag, "_rdata_b"}, rdata_b, '0);
    chk({tag, "_rvalid_a"}, DW'(rvalid_a), '0);
    chk({tag, "_rvalid_b"}, DW'(rvalid_b), '0);
    chk({tag, "_busy"}, DW'(busy), '0);
    chk({tag, "_par_err"}, DW'(par_err), '0);
  endtask

  // Assert reset mid-cycle after the last pending edge has resolved
  task automatic do_reset();
    idle();
    @(posedge clk);
    #3 rst_n = 1'b0;
    model_reset();
    #1 check_outputs_zero("in_reset");
    repeat (2) @(posedge clk);
    #1 check_outputs_zero("in_reset_late");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: pop expectations due this cycle and compare against the DUT
  initial begin
    exp_t  ea, eb;
    bexp_t bb;
    logic  got_a, got_b, pe_exp;
    forever begin
      @(posedge clk);
      #1;
      got_a = 1'b0; got_b = 1'b0; pe_exp = 1'b0;
      while (qa.size() > 0 && qa[0].cyc < cyc) begin
        ea = qa.pop_front();
        chk("stale_a", DW'(ea.cyc), DW'(cyc));
      end
      while (qb.size() > 0 && qb[0].cyc < cyc) begin
        eb = qb.pop_front();
        chk("stale_b", DW'(eb.cyc), DW'(cyc));
      end
      if (qa.size() > 0 && qa[0].cyc == cyc) begin ea = qa.pop_front(); got_a = 1'b1; end
      if (qb.size() > 0 && qb[0].cyc == cyc) begin eb = qb.pop_front(); got_b = 1'b1; end
      chk("rvalid_a", DW'(rvalid_a), DW'(got_a));
      chk("rvalid_b", DW'(rvalid_b), DW'(got_b));
      if (got_a && rvalid_a) begin chk("rdata_a", rdata_a, ea.d); pe_exp = pe_exp | ea.pe; end
      if (got_b && rvalid_b) begin chk("rdata_b", rdata_b, eb.d); pe_exp = pe_exp | eb.pe; end
      if (rst_n) chk("par_err", DW'(par_err), DW'(pe_exp));
      if (qbusy.size() > 0 && qbusy[0].cyc == cyc) begin
        bb = qbusy.pop_front();
        chk("busy", DW'(busy), DW'(bb.b));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    errors = 0; checks = 0;
    wren = 0; waddr = '0; wdata = '0; wbe = '0;
    rden_a = 0; raddr_a = '0; rden_b = 0; raddr_b = '0; clr_req = 0;
    model_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_outputs_zero("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Traffic, then reset mid-stream; afterwards addr 3 reads back zero
    step(1'b1, 2'd3, 16'hDEAD, 2'b11, 1'b1, 2'd0, 1'b0, '0, 1'b0);
    step(1'b1, 2'd0, 16'hBEEF, 2'b11, 1'b1, 2'd3, 1'b1, 2'd3, 1'b0);
    do_reset();
    step(1'b0, '0, '0, '0, 1'b1, 2'd3, 1'b0, '0, 1'b0);
    @(posedge clk);
    #1 chk("t1_rdata_a", rdata_a, 16'h0000);

    // Low-byte write, read back next cycle
    step(1'b1, 2'd2, 16'h77A5, 2'b01, 1'b0, '0, 1'b0, '0, 1'b0);
    step(1'b0, '0, '0, '0, 1'b1, 2'd2, 1'b0, '0, 1'b0);
    @(posedge clk);
    #1 chk("t2_rdata_a", rdata_a, 16'h00A5);

    // Bypass on both ports in the same cycle
    step(1'b1, 2'd1, 16'h3C3C, 2'b11, 1'b1, 2'd1, 1'b1, 2'd1, 1'b0);
    @(posedge clk);
    #1 chk("t3_rdata_a", rdata_a, 16'h3C3C);
    chk("t3_rdata_b", rdata_b, 16'h3C3C);

    // Partial byte-enable merge
    step(1'b1, 2'd0, 16'h1234, 2'b11, 1'b0, '0, 1'b0, '0, 1'b0);
    step(1'b1, 2'd0, 16'hABCD, 2'b10, 1'b0, '0, 1'b0, '0, 1'b0);
    step(1'b1, 2'd0, 16'hFFFF, 2'b00, 1'b0, '0, 1'b0, '0, 1'b0);
    step(1'b0, '0, '0, '0, 1'b1, 2'd0, 1'b0, '0, 1'b0);
    @(posedge clk);
    #1 chk("t4_rdata_a", rdata_a, 16'hAB34);

    // Fill, clear (with a same-cycle write), dropped write/read during busy, read all
    for (int i = 0; i < DEPTH; i++) step(1'b1, AW'(i), 16'hFFFF, 2'b11, 1'b0, '0, 1'b0, '0, 1'b0);
    step(1'b1, 2'd2, 16'h1111, 2'b11, 1'b0, '0, 1'b0, '0, 1'b1);
    step(1'b1, 2'd3, 16'h5555, 2'b11, 1'b1, 2'd3, 1'b0, '0, 1'b1);
    idle(); idle(); idle();
    idle();
    rd2(2'd0, 2'd1);
    rd2(2'd2, 2'd3);
    @(posedge clk);
    #1 chk("t5_rdata_a", rdata_a, 16'h0000);
    chk("t5_rdata_b", rdata_b, 16'h0000);

    // Reset in the middle of a clear sweep
    for (int i = 0; i < DEPTH; i++) step(1'b1, AW'(i), 16'h9999, 2'b11, 1'b0, '0, 1'b0, '0, 1'b0);
    step(1'b0, '0, '0, '0, 1'b0, '0, 1'b0, '0, 1'b1);
    idle();
    do_reset();
    rd2(2'd2, 2'd3);
    idle();

`ifdef REGFILE_PARITY_EN
    // Corrupt the stored parity bit of entry 2 and read it on port B
    step(1'b1, 2'd2, 16'h0F0F, 2'b11, 1'b0, '0, 1'b0, '0, 1'b0);
    @(negedge clk);
    dut.mem_q[2][DW] = ~dut.mem_q[2][DW];
    bad[2] = 1'b1;
    rd2(2'd1, 2'd2);
    rd2(2'd1, 2'd3);
    step(1'b1, 2'd2, 16'h00FF, 2'b01, 1'b1, 2'd2, 1'b0, '0, 1'b0);
    idle();
`endif

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 1) == 1, AW'($urandom), DW'($urandom), BEW'($urandom),
           $urandom_range(0, 2) != 0, AW'($urandom),
           $urandom_range(0, 2) != 0, AW'($urandom),
           $urandom_range(0, 29) == 0);
    end
    repeat (DEPTH + 2) idle();
    @(posedge clk);
    #2;
    chk("drain_qa", DW'(qa.size()), '0);
    chk("drain_qb", DW'(qb.size()), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
